// File: rtl/ising_energy_evaluator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ising_energy_evaluator: streams couplings LANES per cycle, accumulates      |
// | H = -sum(i<j) J_ij*s_i*s_j and tracks the best energy / spin vector seen.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ising_energy_evaluator #(
   parameter int NUM_SPINS = 16,
   parameter int LANES     = 4,
   parameter int J_WIDTH   = 4,
   parameter int H_WIDTH   = J_WIDTH + 2*$clog2(NUM_SPINS)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [NUM_SPINS-1:0]                   spins,
   input  logic                                   clear_best,
   output logic                                   busy,
   output logic                                   j_rd_en,
   output logic [$clog2(NUM_SPINS)-1:0]           j_row,
   output logic [((NUM_SPINS/LANES) > 1 ? $clog2(NUM_SPINS/LANES) : 1)-1:0] j_col_blk,
   input  logic [LANES*J_WIDTH-1:0]               j_rd_data,
   output logic                                   done,
   output logic signed [H_WIDTH-1:0]              energy,
   output logic signed [H_WIDTH-1:0]              best_energy,
   output logic [NUM_SPINS-1:0]                   best_spins,
   output logic                                   best_valid
);

   localparam int c_blocks = NUM_SPINS / LANES;
   localparam int c_row_w  = $clog2(NUM_SPINS);
   localparam int c_blk_w  = (c_blocks > 1) ? $clog2(c_blocks) : 1;
   localparam logic [c_row_w-1:0] c_row_last = c_row_w'(NUM_SPINS - 1);
   localparam logic [c_blk_w-1:0] c_blk_last = c_blk_w'(c_blocks - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                      r_state;
   state_t                      w_state_next;
   logic [c_row_w-1:0]          r_row;
   logic [c_blk_w-1:0]          r_blk;
   logic                        r_vld;
   logic [c_row_w-1:0]          r_prow;
   logic [c_blk_w-1:0]          r_pblk;
   logic [NUM_SPINS-1:0]        r_snap;
   logic signed [H_WIDTH-1:0]   r_acc;
   logic signed [H_WIDTH-1:0]   r_energy;
   logic signed [H_WIDTH-1:0]   r_best_energy;
   logic [NUM_SPINS-1:0]        r_best_spins;
   logic                        r_best_valid;
   logic                        w_last;
   logic signed [H_WIDTH-1:0]   w_term [LANES];
   logic signed [H_WIDTH-1:0]   w_sum;
   logic signed [H_WIDTH-1:0]   w_acc_next;

   assign w_last = (r_row == c_row_last) && (r_blk == c_blk_last);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      j_rd_en      = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_state_next = S_READ;
         end
         S_READ: begin
            j_rd_en = 1'b1;
            if (w_last) w_state_next = S_DRAIN;
         end
         S_DRAIN: w_state_next = S_DONE;
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Diagonal and lower-triangle columns contribute nothing whatever the memory holds.
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic signed [J_WIDTH-1:0] w_j;
      logic signed [H_WIDTH-1:0] w_jx;
      logic [c_row_w-1:0]        w_col;
      assign w_j   = j_rd_data[k*J_WIDTH +: J_WIDTH];
      assign w_jx  = {{(H_WIDTH-J_WIDTH){w_j[J_WIDTH-1]}}, w_j};
      assign w_col = c_row_w'(r_pblk) * c_row_w'(LANES) + c_row_w'(k);
      assign w_term[k] = (w_col <= r_prow) ? '0 :
                         ((r_snap[r_prow] == r_snap[w_col]) ? w_jx : -w_jx);
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < LANES; k++) w_sum = w_sum + w_term[k];
   end

   assign w_acc_next = r_acc - w_sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_row         <= '0;
         r_blk         <= '0;
         r_vld         <= 1'b0;
         r_prow        <= '0;
         r_pblk        <= '0;
         r_snap        <= '0;
         r_acc         <= '0;
         r_energy      <= '0;
         r_best_energy <= '0;
         r_best_spins  <= '0;
         r_best_valid  <= 1'b0;
      end else begin
         r_vld  <= j_rd_en;
         r_prow <= r_row;
         r_pblk <= r_blk;
         if (r_vld) r_acc <= w_acc_next;
         if (r_state == S_IDLE && start) begin
            r_snap <= spins;
            r_acc  <= '0;
            r_row  <= '0;
            r_blk  <= '0;
         end else if (j_rd_en) begin
            if (r_blk == c_blk_last) begin
               r_blk <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_blk <= r_blk + 1'b1;
            end
         end
         // The final data beat lands in DRAIN, so capture the result with it folded in.
         if (r_state == S_DRAIN) r_energy <= w_acc_next;
         // A clear in the DONE cycle acts before the compare, so the new run is always kept.
         if (r_state == S_DONE) begin
            if (clear_best || !r_best_valid || (r_energy < r_best_energy)) begin
               r_best_energy <= r_energy;
               r_best_spins  <= r_snap;
               r_best_valid  <= 1'b1;
            end
         end else if (clear_best) begin
            r_best_valid <= 1'b0;
         end
      end
   end

   assign j_row       = r_row;
   assign j_col_blk   = r_blk;
   assign energy      = r_energy;
   assign best_energy = r_best_energy;
   assign best_spins  = r_best_spins;
   assign best_valid  = r_best_valid;

endmodule
`default_nettype wire

// File: tb/tb_ising_energy_evaluator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ising_energy_evaluator: scoreboard bench with a coupling-memory model    |
// | and a pairwise-sum reference for the Ising energy and best-record tracking. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_ising_energy_evaluator;

   localparam int N  = 16;
   localparam int L  = 4;
   localparam int JW = 4;
   localparam int HW = 12;
   localparam int RUN_LEN = 65;   // edges from accept to the done cycle

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic                 clear_best = 1'b0;
   logic [N-1:0]         spins = '0;
   logic                 busy, j_rd_en, done, best_valid;
   logic [3:0]           j_row;
   logic [1:0]           j_col_blk;
   logic [L*JW-1:0]      j_rd_data = '0;
   logic signed [HW-1:0] energy, best_energy;
   logic [N-1:0]         best_spins;

   ising_energy_evaluator #(.NUM_SPINS(N), .LANES(L), .J_WIDTH(JW)) dut (
      .clk(clk), .reset(reset), .start(start), .spins(spins), .clear_best(clear_best),
      .busy(busy), .j_rd_en(j_rd_en), .j_row(j_row), .j_col_blk(j_col_blk),
      .j_rd_data(j_rd_data), .done(done), .energy(energy), .best_energy(best_energy),
      .best_spins(best_spins), .best_valid(best_valid)
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges <= edges + 1;

   // Coupling memory: one-cycle read latency, garbage when not read.
   logic signed [JW-1:0] jm [N][N];
   always @(posedge clk) begin : p_mem
      logic [L*JW-1:0] d;
      d = 16'($urandom);
      if (j_rd_en)
         for (int k = 0; k < L; k++) d[k*JW +: JW] = jm[j_row][int'(j_col_blk)*L + k];
      j_rd_data <= d;
   end

   function automatic int ref_energy(input logic [N-1:0] s);
      int e = 0;
      for (int i = 0; i < N; i++)
         for (int j = i + 1; j < N; j++)
            e -= int'(jm[i][j]) * ((s[i] == s[j]) ? 1 : -1);
      return e;
   endfunction

   typedef struct {
      int           s_edge;
      int           energy;
      logic [N-1:0] sp;
   } run_t;
   run_t q[$];

   int           n_chk = 0;
   int           n_fail = 0;
   int           me = 0, mb = 0;
   logic         mv = 1'b0;
   logic [N-1:0] ms = '0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edges);
      end
   endtask

   // Monitor: derives expected control/outputs from the scoreboard head.
   always @(negedge clk) begin : p_mon
      int d;
      bit eb, ed, er, take;
      if (!reset) begin
         q.delete();
         mv = 1'b0; me = 0; mb = 0; ms = '0;
         chk("reset_outputs_zero",
             (busy | done | j_rd_en | best_valid | (|j_row) | (|j_col_blk) |
              (|energy) | (|best_energy) | (|best_spins)) ? 1 : 0, 0);
      end else begin
         eb = 0; ed = 0; er = 0; d = 0; take = 0;
         if (q.size() > 0) begin
            d  = edges - q[0].s_edge;
            eb = (d >= 0) && (d <= RUN_LEN);
            er = (d >= 0) && (d < N*N/L);
            ed = (d == RUN_LEN);
         end
         chk("busy", int'(busy), int'(eb));
         chk("done", int'(done), int'(ed));
         chk("j_rd_en", int'(j_rd_en), int'(er));
         if (er) begin
            chk("j_row", int'(j_row), d / (N/L));
            chk("j_col_blk", int'(j_col_blk), d % (N/L));
         end
         if (ed) begin
            me   = q[0].energy;
            take = clear_best || !mv || (me < mb);
         end
         chk("energy", int'(energy), me);
         chk("best_valid", int'(best_valid), int'(mv));
         chk("best_energy", int'(best_energy), mb);
         chk("best_spins", int'(best_spins), int'(ms));
         if (ed) begin
            if (take) begin
               mb = me; ms = q[0].sp; mv = 1'b1;
            end
            void'(q.pop_front());
         end else if (clear_best) begin
            mv = 1'b0;
         end
      end
   end

   task automatic fill(input int up, input int lo);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            jm[i][j] = (j > i) ? 4'(up) : 4'(lo);
   endtask

   task automatic to_cycle(input int ne, input int k);
      while (edges != ne + k - 1) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_clear();
      clear_best = 1'b1;
      @(posedge clk); #1;
      clear_best = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run(input logic [N-1:0] s, input int pulse_at, input int reset_at,
                      input bit clr_done);
      int   ne;
      run_t r;
      spins = s;
      start = 1'b1;
      @(posedge clk); #1;
      ne = edges;
      start = 1'b0;
      spins = 16'($urandom);
      r.s_edge = ne; r.energy = ref_energy(s); r.sp = s;
      q.push_back(r);
      if (pulse_at > 0) begin
         to_cycle(ne, pulse_at);
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      if (reset_at > 0) begin
         to_cycle(ne, reset_at);
         reset = 1'b0;
         repeat (2) @(posedge clk);
         #1 reset = 1'b1;
      end
      if (clr_done) begin
         to_cycle(ne, RUN_LEN + 1);
         clear_best = 1'b1;
         @(posedge clk); #1;
         clear_best = 1'b0;
      end
      for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         $display("FAIL run_timeout: got pending=%0d expected 0", q.size());
         $fatal(1, "scoreboard never drained");
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      fill(0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      run(16'h1234, 0, 0, 0);            // all-zero couplings
      fill(1, -8);
      run(16'hFFFF, 0, 0, 0);            // -120
      run(16'hAAAA, 0, 0, 0);            // +8, best unchanged
      pulse_clear();
      fill(-8, -8);
      run(16'hFFFF, 0, 0, 0);            // +960
      fill(7, 7);
      run(16'hFFFF, 0, 0, 0);            // -840
      fill(1, -8);
      run(16'h5A3C, 10, 0, 0);           // spurious start mid-run
      run(16'h0F0F, 0, 20, 0);           // aborted by reset
      run(16'hFFFF, 0, 0, 0);            // full run after abort
      fill(7, 7);
      run(16'hFFFF, 0, 0, 0);            // -840 as a strong record
      fill(1, -8);
      run(16'hFFFF, 0, 0, 1);            // clear in done cycle keeps -120
      pulse_clear();
      run(16'hAAAA, 0, 0, 0);            // +8 becomes best

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) jm[i][j] = 4'($urandom);
         if ($urandom_range(0, 2) == 0) pulse_clear();
         run(16'($urandom), 0, 0, bit'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
